// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide sequencer.
package md_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_MUL_WAIT,
      MD_DIV_RUN,
      MD_DIV_FIX
   } md_state_e;

   localparam int unsigned DIV_ITERS = 32;
   localparam int unsigned CNT_W     = 5;

endpackage

// File: rtl/md_if.sv
// EX-stage <-> mul/div unit request and result bundle.
interface md_if #(
   parameter int unsigned DATA_W = 32
);
   logic              md_start;
   logic [1:0]        md_op;
   logic [DATA_W-1:0] md_a;
   logic [DATA_W-1:0] md_b;
   logic              md_flush;
   logic              md_rd_hi;
   logic              md_rd_lo;
   logic              md_wr_hi;
   logic              md_wr_lo;
   logic              md_stall;
   logic              md_busy;
   logic              md_done;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   modport master (
      output md_start, md_op, md_a, md_b, md_flush, md_rd_hi, md_rd_lo, md_wr_hi, md_wr_lo,
      input  md_stall, md_busy, md_done, hi, lo
   );

   modport slave (
      input  md_start, md_op, md_a, md_b, md_flush, md_rd_hi, md_rd_lo, md_wr_hi, md_wr_lo,
      output md_stall, md_busy, md_done, hi, lo
   );
endinterface

// File: rtl/md_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module md_div_step #(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0] rem_i,
   input  logic [DATA_W-1:0] quo_i,
   input  logic [DATA_W-1:0] dvs_i,
   output logic [DATA_W-1:0] rem_o,
   output logic [DATA_W-1:0] quo_o
);

   // One extra bit: the shifted remainder can exceed DATA_W bits when dvs_i >= 2^(DATA_W-1).
   logic [DATA_W:0] shifted;

   always_comb begin
      shifted = {rem_i, quo_i[DATA_W-1]};
      if (shifted >= {1'b0, dvs_i}) begin
         rem_o = shifted[DATA_W-1:0] - dvs_i;
         quo_o = {quo_i[DATA_W-2:0], 1'b1};
      end else begin
         rem_o = shifted[DATA_W-1:0];
         quo_o = {quo_i[DATA_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/md_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; stalls EX-stage users while busy.
module md_ctrl
   import md_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MUL_LAT = 4
) (
   input logic  clk,
   input logic  rst_n,
   md_if.slave  bus
);

   md_state_e           state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic                done_q, done_d;
   logic [2*DATA_W-1:0] prod_q, prod_d;
   logic [DATA_W-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_q, a_d;
   logic                qneg_q, qneg_d, rneg_q, rneg_d, dvz_q, dvz_d;

   logic                idle, accept, signed_op;
   logic [DATA_W-1:0]   abs_a, abs_b, rem_nx, quo_nx;
   logic [2*DATA_W-1:0] ext_a, ext_b;

   assign idle      = (state_q == MD_IDLE);
   assign accept    = idle && bus.md_start && !bus.md_flush;
   assign signed_op = (bus.md_op == MD_MULT) || (bus.md_op == MD_DIV);

   assign abs_a = (signed_op && bus.md_a[DATA_W-1]) ? -bus.md_a : bus.md_a;
   assign abs_b = (signed_op && bus.md_b[DATA_W-1]) ? -bus.md_b : bus.md_b;
   assign ext_a = {{DATA_W{signed_op & bus.md_a[DATA_W-1]}}, bus.md_a};
   assign ext_b = {{DATA_W{signed_op & bus.md_b[DATA_W-1]}}, bus.md_b};

   md_div_step #(
      .DATA_W (DATA_W)
   ) u_div_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .dvs_i (dvs_q),
      .rem_o (rem_nx),
      .quo_o (quo_nx)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      prod_d  = prod_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      a_d     = a_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dvz_d   = dvz_q;
      unique case (state_q)
         MD_IDLE: begin
            if (accept) begin
               if (!bus.md_op[1]) begin
                  // Low 2*DATA_W bits of the extended product are exact for both signednesses.
                  prod_d  = ext_a * ext_b;
                  cnt_d   = CNT_W'(MUL_LAT - 1);
                  state_d = MD_MUL_WAIT;
               end else begin
                  rem_d   = '0;
                  quo_d   = abs_a;
                  dvs_d   = abs_b;
                  a_d     = bus.md_a;
                  qneg_d  = signed_op && (bus.md_a[DATA_W-1] ^ bus.md_b[DATA_W-1]);
                  rneg_d  = signed_op && bus.md_a[DATA_W-1];
                  dvz_d   = (bus.md_b == '0);
                  cnt_d   = CNT_W'(DIV_ITERS - 1);
                  state_d = MD_DIV_RUN;
               end
            end else if (!bus.md_flush && !bus.md_start) begin
               if (bus.md_wr_hi) hi_d = bus.md_a;
               if (bus.md_wr_lo) lo_d = bus.md_a;
            end
         end
         MD_MUL_WAIT: begin
            if (cnt_q == '0) begin
               {hi_d, lo_d} = prod_q;
               done_d       = 1'b1;
               state_d      = MD_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         MD_DIV_RUN: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            if (cnt_q == '0) state_d = MD_DIV_FIX;
            else             cnt_d   = cnt_q - 1'b1;
         end
         MD_DIV_FIX: begin
            if (dvz_q) begin
               lo_d = '1;
               hi_d = a_q;
            end else begin
               lo_d = qneg_q ? -quo_q : quo_q;
               hi_d = rneg_q ? -rem_q : rem_q;
            end
            done_d  = 1'b1;
            state_d = MD_IDLE;
         end
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         prod_q  <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         a_q     <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dvz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         prod_q  <= prod_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         a_q     <= a_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dvz_q   <= dvz_d;
      end
   end

   assign bus.md_busy  = !idle;
   assign bus.md_done  = done_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign bus.md_stall = bus.md_busy && (bus.md_start || bus.md_rd_hi || bus.md_rd_lo ||
                                         bus.md_wr_hi || bus.md_wr_lo);

   // Start together with MTHI/MTLO is an illegal decode; start wins in hardware.
   a_start_wr_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(idle && bus.md_start && (bus.md_wr_hi || bus.md_wr_lo)));

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed boundary cases plus randomized ops vs. an arithmetic model.
module tb_md_ctrl;
   import md_pkg::*;

   localparam int unsigned MUL_LAT = 4;
   localparam int unsigned DIV_BUSY = 33;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   passed = 0;
   int   total = 0;

   md_if #(.DATA_W(32)) ifc ();

   md_ctrl #(
      .DATA_W  (32),
      .MUL_LAT (MUL_LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   // Reference: {hi, lo} from plain 64-bit arithmetic.
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] res;
      if (op == MD_MULT) begin
         sa  = longint'($signed(a));
         sb  = longint'($signed(b));
         res = 64'(sa * sb);
      end else if (op == MD_MULTU) begin
         res = {32'b0, a} * {32'b0, b};
      end else if (b == 32'd0) begin
         res = {a, 32'hFFFF_FFFF};
      end else begin
         if (op == MD_DIV) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
         end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
         end
         q   = sa / sb;
         r   = sa % sb;
         res = {r[31:0], q[31:0]};
      end
      return res;
   endfunction

   task automatic clear_inputs();
      ifc.md_start = 1'b0;
      ifc.md_op    = 2'b00;
      ifc.md_a     = '0;
      ifc.md_b     = '0;
      ifc.md_flush = 1'b0;
      ifc.md_rd_hi = 1'b0;
      ifc.md_rd_lo = 1'b0;
      ifc.md_wr_hi = 1'b0;
      ifc.md_wr_lo = 1'b0;
   endtask

   // Issue one op from idle; report busy length and number of done pulses seen.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cyc, output int done_cnt);
      @(negedge clk);
      ifc.md_start = 1'b1;
      ifc.md_op    = op;
      ifc.md_a     = a;
      ifc.md_b     = b;
      @(negedge clk);
      ifc.md_start = 1'b0;
      busy_cyc = 0;
      done_cnt = 0;
      while (ifc.md_busy && busy_cyc < 200) begin
         busy_cyc++;
         if (ifc.md_done) done_cnt++;
         @(negedge clk);
      end
      if (ifc.md_done) done_cnt++;
      @(negedge clk);
      if (ifc.md_done) done_cnt++;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({ifc.hi, ifc.lo} !== 64'd0) $display("FAIL reset_hilo: got %h expected 0", {ifc.hi, ifc.lo});
      else passed++;
      total++;
      if ({ifc.md_busy, ifc.md_done, ifc.md_stall} !== 3'b000)
         $display("FAIL reset_flags: got %b expected 000", {ifc.md_busy, ifc.md_done, ifc.md_stall});
      else passed++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mult();
      int bc, dc;
      do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, bc, dc);
      total++;
      if (bc !== MUL_LAT) $display("FAIL mult_busy: got %0d expected %0d", bc, MUL_LAT);
      else passed++;
      total++;
      if (dc !== 1) $display("FAIL mult_done: got %0d pulses expected 1", dc);
      else passed++;
      total++;
      if ({ifc.hi, ifc.lo} !== 64'hFFFF_FFFF_FFFF_FFFA)
         $display("FAIL mult_result: got %h expected FFFFFFFFFFFFFFFA", {ifc.hi, ifc.lo});
      else passed++;
   endtask

   task automatic test_divu_mflo();
      int n;
      @(negedge clk);
      ifc.md_start = 1'b1;
      ifc.md_op    = MD_DIVU;
      ifc.md_a     = 32'd100;
      ifc.md_b     = 32'd7;
      @(negedge clk);
      ifc.md_start = 1'b0;
      ifc.md_rd_lo = 1'b1;
      #1;
      n = 0;
      while (ifc.md_stall && n < 200) begin
         n++;
         @(negedge clk);
         #1;
      end
      total++;
      if (n !== DIV_BUSY) $display("FAIL divu_stall_len: got %0d expected %0d", n, DIV_BUSY);
      else passed++;
      total++;
      if (ifc.lo !== 32'd14) $display("FAIL divu_mflo: got %0d expected 14", ifc.lo);
      else passed++;
      total++;
      if (ifc.hi !== 32'd2) $display("FAIL divu_hi: got %0d expected 2", ifc.hi);
      else passed++;
      total++;
      if (ifc.md_done !== 1'b1) $display("FAIL divu_done: got %b expected 1", ifc.md_done);
      else passed++;
      ifc.md_rd_lo = 1'b0;
   endtask

   task automatic test_div_signed();
      int bc, dc;
      do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, bc, dc);
      total++;
      if ({ifc.hi, ifc.lo} !== 64'hFFFF_FFFF_FFFF_FFFD)
         $display("FAIL div_neg: got %h expected FFFFFFFFFFFFFFFD", {ifc.hi, ifc.lo});
      else passed++;
      total++;
      if (bc !== DIV_BUSY) $display("FAIL div_busy: got %0d expected %0d", bc, DIV_BUSY);
      else passed++;
      do_op(MD_DIV, 32'd7, 32'd0, bc, dc);
      total++;
      if ({ifc.hi, ifc.lo} !== {32'd7, 32'hFFFF_FFFF})
         $display("FAIL div_by_zero: got %h expected 00000007FFFFFFFF", {ifc.hi, ifc.lo});
      else passed++;
      total++;
      if (bc !== DIV_BUSY) $display("FAIL div0_busy: got %0d expected %0d", bc, DIV_BUSY);
      else passed++;
      do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc);
      total++;
      if ({ifc.hi, ifc.lo} !== 64'h0000_0000_8000_0000 || $isunknown({ifc.hi, ifc.lo}))
         $display("FAIL div_overflow: got %h expected 0000000080000000", {ifc.hi, ifc.lo});
      else passed++;
   endtask

   task automatic test_back_to_back();
      int n, bc;
      @(negedge clk);
      ifc.md_wr_hi = 1'b1;
      ifc.md_a     = 32'h1234;
      @(negedge clk);
      ifc.md_wr_hi = 1'b0;
      total++;
      if (ifc.hi !== 32'h1234) $display("FAIL mthi: got %h expected 1234", ifc.hi);
      else passed++;
      ifc.md_start = 1'b1;
      ifc.md_op    = MD_DIV;
      ifc.md_a     = 32'd50;
      ifc.md_b     = 32'd3;
      @(negedge clk);
      ifc.md_op = MD_MULTU;
      ifc.md_a  = 32'h0001_0000;
      ifc.md_b  = 32'h0001_0000;
      #1;
      n = 0;
      while (ifc.md_stall && n < 200) begin
         n++;
         @(negedge clk);
         #1;
      end
      total++;
      if (n !== DIV_BUSY) $display("FAIL b2b_stall_len: got %0d expected %0d", n, DIV_BUSY);
      else passed++;
      total++;
      if ({ifc.hi, ifc.lo} !== {32'd2, 32'd16})
         $display("FAIL b2b_div_result: got %h expected 0000000200000010", {ifc.hi, ifc.lo});
      else passed++;
      @(negedge clk);
      ifc.md_start = 1'b0;
      total++;
      if (ifc.md_busy !== 1'b1) $display("FAIL b2b_accept: got busy %b expected 1", ifc.md_busy);
      else passed++;
      bc = 0;
      while (ifc.md_busy && bc < 200) begin
         bc++;
         @(negedge clk);
      end
      total++;
      if ({ifc.hi, ifc.lo} !== {32'd1, 32'd0})
         $display("FAIL b2b_multu: got %h expected 0000000100000000", {ifc.hi, ifc.lo});
      else passed++;
   endtask

   task automatic test_reset_mid_div();
      int dc;
      @(negedge clk);
      ifc.md_wr_lo = 1'b1;
      ifc.md_a     = 32'hABCD;
      @(negedge clk);
      ifc.md_wr_lo = 1'b0;
      ifc.md_start = 1'b1;
      ifc.md_op    = MD_DIV;
      ifc.md_a     = 32'd1000;
      ifc.md_b     = 32'd9;
      @(negedge clk);
      ifc.md_start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if ({ifc.hi, ifc.lo, ifc.md_busy} !== 65'd0)
         $display("FAIL rst_mid_div: got hi %h lo %h busy %b expected all 0",
                  ifc.hi, ifc.lo, ifc.md_busy);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      dc = 0;
      repeat (40) begin
         @(negedge clk);
         if (ifc.md_done || ifc.md_busy) dc++;
      end
      total++;
      if (dc !== 0) $display("FAIL rst_no_done: got %0d active cycles expected 0", dc);
      else passed++;
      ifc.md_start = 1'b1;
      ifc.md_flush = 1'b1;
      @(negedge clk);
      ifc.md_start = 1'b0;
      ifc.md_flush = 1'b0;
      total++;
      if (ifc.md_busy !== 1'b0) $display("FAIL flush_start: got busy %b expected 0", ifc.md_busy);
      else passed++;
   endtask

   task automatic test_random();
      int bc, dc;
      logic [1:0]  op;
      logic [31:0] a, b;
      logic [63:0] exp;
      for (int i = 0; i < 24; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 9));
            2:       b = -32'($urandom_range(1, 9));
            3:       b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         if (i == 5) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end
         exp = model(op, a, b);
         do_op(op, a, b, bc, dc);
         total++;
         if ({ifc.hi, ifc.lo} !== exp)
            $display("FAIL rand_result[%0d] op %0d a %h b %h: got %h expected %h",
                     i, op, a, b, {ifc.hi, ifc.lo}, exp);
         else passed++;
         total++;
         if (bc !== (op[1] ? DIV_BUSY : MUL_LAT) || dc !== 1)
            $display("FAIL rand_timing[%0d]: got busy %0d done %0d expected %0d/1",
                     i, bc, dc, op[1] ? DIV_BUSY : MUL_LAT);
         else passed++;
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_mult();
      test_divu_mflo();
      test_div_signed();
      test_back_to_back();
      test_reset_mid_div();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multi-cycle multiply/divide sequencer and HI/LO register owner for the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU from the EX stage and runs them over several cycles.
- Serialises MFHI/MFLO/MTHI/MTLO against in-flight operations.
- Drives a stall request that the hazard unit ORs into PCwrite/IFIDwrite deassertion and IDEX hold.

Parameters:
- DATA_W, 32, operand/HI/LO width; only 32 is supported and verified.
- MUL_LAT, 4, multiply busy cycles; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- md_start  in  1  EX-stage instruction is a mul/div op
- md_op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- md_a  in  32  rs operand (dividend or multiplicand), already forwarded
- md_b  in  32  rt operand (divisor or multiplier), already forwarded
- md_flush  in  1  EX-stage instruction is being squashed this cycle
- md_rd_hi  in  1  EX-stage MFHI
- md_rd_lo  in  1  EX-stage MFLO
- md_wr_hi  in  1  EX-stage MTHI, with data on md_a
- md_wr_lo  in  1  EX-stage MTLO, with data on md_a
- md_stall  out  1  hold PC, IF/ID and ID/EX; bubble into EX/MEM
- md_busy  out  1  operation in flight
- md_done  out  1  one-cycle pulse in the cycle after HI/LO update
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (asynchronous, any state, mid-operation included): state IDLE; hi=0, lo=0, md_busy=0, md_done=0, iteration counter=0. Any in-flight operation is discarded.
- States:
  - IDLE: no operation in flight.
  - MUL_WAIT: counter runs MUL_LAT-1 down to 0; the product is latched at accept.
  - DIV_RUN: 32 restoring iterations on magnitudes, counter 31 down to 0.
  - DIV_FIX: sign correction, then hi/lo written.
- md_busy = (state != IDLE), registered-state decode.
- Accept: in IDLE with md_start=1 and md_flush=0, the next edge enters MUL_WAIT (md_op[1]=0) or DIV_RUN (md_op[1]=1). md_start with md_flush=1 is ignored.
- MULT/MULTU:
  - Full 64-bit product; signed for MULT, unsigned for MULTU.
  - At the edge where MUL_WAIT has counter==0: {hi,lo}=product, state becomes IDLE, md_done=1 for the following cycle.
  - md_busy is high for exactly MUL_LAT cycles.
- DIV/DIVU:
  - At DIV_RUN entry, the operand magnitudes are latched (signed ops only).
  - DIV_FIX writes lo=quotient and hi=remainder. Quotient sign = sign(a) xor sign(b); remainder takes the sign of the dividend.
  - md_busy is high for exactly 33 cycles.
- Boundary results:
  - Divide by zero: lo=32'hFFFF_FFFF, hi=md_a. The operation still takes 33 cycles.
  - DIV of 32'h8000_0000 by 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
- md_stall (combinational) = md_busy & (md_start | md_rd_hi | md_rd_lo | md_wr_hi | md_wr_lo).
  - Stall drops in the first cycle with md_busy=0.
  - A stalled MFHI/MFLO reads the updated hi/lo in that cycle.
  - A stalled md_start is accepted in that cycle. Back-to-back ops therefore have one idle cycle between busy windows.
- MTHI/MTLO:
  - Only in IDLE with md_flush=0; the next edge writes hi (or lo) = md_a.
  - Simultaneous md_start and md_wr_* in IDLE: start wins and the write is ignored (illegal encoding; an assertion flags it).
- md_rd_* does not modify state; hi/lo are always readable outputs.
- md_flush while busy does not cancel the in-flight operation; only the EX-stage request is dropped.
- md_done is never asserted for a flushed or reset-discarded operation.

Decomposition:
- Package md_pkg:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - state encoding MD_IDLE, MD_MUL_WAIT, MD_DIV_RUN, MD_DIV_FIX;
  - constant DIV_ITERS=32.
- Sub-module md_div_step: combinational single restoring-division step.
  - Inputs: partial remainder, quotient shift register, divisor.
  - Outputs: next remainder and next quotient.
  - Instanced once; md_ctrl holds the FSM, counters, hi/lo and sign fix-up.

Test Plan:
- MULT a=32'hFFFF_FFFE (-2), b=3, MUL_LAT=4 -> md_busy high 4 cycles; hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA; md_done pulses once.
- DIVU a=100, b=7, then MFLO issued the next cycle -> md_stall high until busy drops after 33 cycles; lo=14, hi=2; MFLO sees 14.
- DIV a=-7, b=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). DIV a=7, b=0 -> lo=32'hFFFF_FFFF, hi=7.
- DIV a=32'h8000_0000, b=32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0, no X.
- MTHI 32'h1234 in IDLE, then MULTU 0x10000*0x10000 issued while another DIV is busy -> MTHI visible next cycle; MULTU stalls and is then accepted; final hi=1, lo=0.
- rst_n low at cycle 10 of a DIV -> hi=lo=0 and md_busy=0 immediately; no md_done; md_start with md_flush=1 afterwards -> md_busy stays 0.
